// File: rtl/acc_pack_pkg.sv
// Shared constants for the accumulator frame packer: header magic, header
// field offsets within the 512-bit beat, and the framing FSM encoding.
package acc_pack_pkg;

  localparam logic [31:0] HDR_MAGIC     = 32'h5A5A_A5A5;
  localparam int          HDR_MAGIC_LSB = 480;
  localparam int          HDR_FCNT_LSB  = 448;
  localparam int          HDR_ENC_LSB   = 384;
  localparam int          HDR_LEN_LSB   = 368;
  localparam int          HDR_LOSS_BIT  = 367;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } pack_state_e;

endpackage

// File: rtl/acc_sync_fifo.sv
// Synchronous FIFO with registered full/empty; head entry is visible on
// o_rdat without popping so the packer can peek at the next sample.
module acc_sync_fifo #(
  parameter int WIDTH = 576,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_push   = i_wr && !r_full;
  assign w_pop    = i_rd && !r_empty;
  assign w_cnt_nx = r_cnt + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt   <= w_cnt_nx;
      r_full  <= (w_cnt_nx == CW'(DEPTH));
      r_empty <= (w_cnt_nx == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdat;
  end

  assign o_rdat  = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/cmip_bit_sync_imp.sv
// Multi-flop single-bit synchronizer for quasi-static configuration inputs.
module cmip_bit_sync_imp #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/acc_frame_pack.sv
// Packs scaled accumulator samples into frames: one header beat followed by
// FRAME_LEN data beats, through a registered valid/ready output stage.
module acc_frame_pack
  import acc_pack_pkg::*;
#(
  parameter int DATA_WD    = 512,
  parameter int HEAD_WD    = 64,
  parameter int FRAME_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_rst,
  input  logic               cfg_pack_en,
  input  logic               acc_ivld,
  input  logic [DATA_WD-1:0] acc_idat,
  input  logic [HEAD_WD-1:0] enc_idat,
  input  logic               pack_ordy,
  output logic               pack_ovld,
  output logic [DATA_WD-1:0] pack_odat,
  output logic               pack_osof,
  output logic               pack_olast,
  output logic [31:0]        frame_cnt,
  output logic [31:0]        drop_cnt
);

  localparam int             FW        = DATA_WD + HEAD_WD;
  localparam int             BW        = $clog2(FRAME_LEN);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(FRAME_LEN - 1);

  logic               w_en, w_full, w_empty, w_drop, w_hs, w_hdr_hs;
  logic [FW-1:0]      w_head;
  logic [DATA_WD-1:0] w_hdr;
  logic               w_ld_hdr, w_ld_dat, w_bubble;
  logic [BW-1:0]      w_beat_nx;
  pack_state_e        r_state, w_state_nx;
  logic [BW-1:0]      r_beat;
  logic               r_ovld, r_osof, r_olast, r_loss, r_loss_late;
  logic [DATA_WD-1:0] r_odat;
  logic [31:0]        r_frame_cnt, r_drop_cnt;

  cmip_bit_sync_imp #(.STAGES(3)) u_en_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (cfg_pack_en),
    .o_q   (w_en)
  );

  acc_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (cfg_rst),
    .i_wr    (acc_ivld && w_en),
    .i_wdat  ({enc_idat, acc_idat}),
    .i_rd    (w_ld_dat),
    .o_rdat  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_drop   = acc_ivld && w_en && w_full;
  assign w_hs     = r_ovld && pack_ordy;
  assign w_hdr_hs = (r_state == ST_HEAD) && w_hs;

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_MAGIC_LSB +: 32]     = HDR_MAGIC;
    w_hdr[HDR_FCNT_LSB +: 32]      = r_frame_cnt;
    w_hdr[HDR_ENC_LSB +: HEAD_WD]  = w_head[FW-1 -: HEAD_WD];
    w_hdr[HDR_LEN_LSB +: 16]       = 16'(FRAME_LEN);
    w_hdr[HDR_LOSS_BIT]            = r_loss;
  end

  // State names what the output register holds; data beats pop on load.
  always_comb begin
    w_state_nx = r_state;
    w_ld_hdr   = 1'b0;
    w_ld_dat   = 1'b0;
    w_bubble   = 1'b0;
    w_beat_nx  = r_beat;
    case (r_state)
      ST_IDLE: if (!w_empty && w_en) begin
        w_ld_hdr   = 1'b1;
        w_state_nx = ST_HEAD;
      end
      ST_HEAD: if (w_hs) begin
        w_beat_nx  = '0;
        w_state_nx = ST_DATA;
        if (!w_empty) w_ld_dat = 1'b1;
        else          w_bubble = 1'b1;
      end
      ST_DATA: begin
        if (w_hs && r_olast) begin
          if (!w_empty && w_en) begin
            w_ld_hdr   = 1'b1;
            w_state_nx = ST_HEAD;
          end else begin
            w_bubble   = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end else if (w_hs || !r_ovld) begin
          if (w_hs) w_beat_nx = r_beat + BW'(1);
          if (!w_empty) w_ld_dat = 1'b1;
          else          w_bubble = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cfg_rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_ovld      <= 1'b0;
      r_osof      <= 1'b0;
      r_olast     <= 1'b0;
      r_odat      <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_loss      <= 1'b0;
      r_loss_late <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
      if (w_ld_hdr) begin
        r_ovld  <= 1'b1;
        r_osof  <= 1'b1;
        r_olast <= 1'b0;
        r_odat  <= w_hdr;
      end else if (w_ld_dat) begin
        r_ovld  <= 1'b1;
        r_osof  <= 1'b0;
        r_olast <= (w_beat_nx == LAST_BEAT);
        r_odat  <= w_head[DATA_WD-1:0];
      end else if (w_bubble) begin
        r_ovld  <= 1'b0;
        r_osof  <= 1'b0;
        r_olast <= 1'b0;
      end
      if (w_hdr_hs) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
      // A header already sitting in the output reg cannot report losses that
      // happen while it waits; those carry over to the next header.
      if (w_hdr_hs) r_loss <= w_drop || r_loss_late;
      else          r_loss <= r_loss || w_drop;
      if (w_ld_hdr) r_loss_late <= w_drop;
      else          r_loss_late <= r_loss_late || w_drop;
    end
  end

  assign pack_ovld  = r_ovld;
  assign pack_odat  = r_odat;
  assign pack_osof  = r_osof;
  assign pack_olast = r_olast;
  assign frame_cnt  = r_frame_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_acc_frame_pack.sv
// Directed bench for acc_frame_pack with FRAME_LEN=4: frame layout, overflow,
// random backpressure ordering, enable drop and soft clear mid-frame.
module tb_acc_frame_pack;

  logic         clk = 1'b0;
  logic         rst_n, cfg_rst, cfg_pack_en, acc_ivld, pack_ordy;
  logic [511:0] acc_idat;
  logic [63:0]  enc_idat;
  logic         pack_ovld, pack_osof, pack_olast;
  logic [511:0] pack_odat;
  logic [31:0]  frame_cnt, drop_cnt;

  acc_frame_pack #(.DATA_WD(512), .HEAD_WD(64), .FRAME_LEN(4), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_pack_en(cfg_pack_en),
    .acc_ivld(acc_ivld), .acc_idat(acc_idat), .enc_idat(enc_idat),
    .pack_ordy(pack_ordy), .pack_ovld(pack_ovld), .pack_odat(pack_odat),
    .pack_osof(pack_osof), .pack_olast(pack_olast),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic sof; logic last; logic [511:0] dat; int cyc; } beat_t;
  typedef struct { logic sof; logic last; logic [511:0] dat; } exp_t;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  beat_t        q[$];
  logic         p_v = 1'b0, p_r = 1'b0, p_ok = 1'b0, p_s = 1'b0, p_l = 1'b0;
  logic [511:0] p_d = '0;

  task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] hdr(input logic [31:0] fc, input logic [63:0] enc,
                                       input logic loss);
    logic [511:0] h;
    h = '0;
    h[511:480] = 32'h5A5A_A5A5;
    h[479:448] = fc;
    h[447:384] = enc;
    h[383:368] = 16'd4;
    h[367]     = loss;
    return h;
  endfunction

  // Output monitor: records handshaken beats and checks hold-during-stall.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (p_ok && p_v && !p_r)
      chk("stall_hold", {pack_ovld, pack_osof, pack_olast, pack_odat}, {1'b1, p_s, p_l, p_d});
    if (pack_ovld && pack_ordy && rst_n && !cfg_rst)
      q.push_back('{sof: pack_osof, last: pack_olast, dat: pack_odat, cyc: cyc});
    p_v  <= pack_ovld;
    p_r  <= pack_ordy;
    p_ok <= rst_n && !cfg_rst;
    p_s  <= pack_osof;
    p_l  <= pack_olast;
    p_d  <= pack_odat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] d, input logic [63:0] e);
    acc_ivld = 1'b1;
    acc_idat = d;
    enc_idat = e;
    tick();
    acc_ivld = 1'b0;
  endtask

  task automatic soft_clear();
    cfg_rst = 1'b1;
    tick();
    cfg_rst = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    int i;
    i = 0;
    while (q.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk(nm, q.size(), n);
  endtask

  exp_t           tbl[5];
  beat_t          wb;
  logic [511:0]   din_q[$];
  logic [63:0]    enc_q[$];
  logic [31:0]    dc_save;
  int             nseq, nfrm, nhdr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, hdr(32'd0, 64'h100, 1'b0)};
    for (int i = 1; i < 5; i++) tbl[i] = '{1'b0, (i == 4), 512'(i - 1)};

    rst_n = 1'b0; cfg_rst = 1'b0; cfg_pack_en = 1'b1; acc_ivld = 1'b0;
    acc_idat = '0; enc_idat = '0; pack_ordy = 1'b1;
    repeat (3) tick();
    chk("rst_ovld", pack_ovld, 1'b0);
    chk("rst_sof", pack_osof, 1'b0);
    chk("rst_last", pack_olast, 1'b0);
    chk("rst_odat", pack_odat, 512'd0);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Basic frame and header latency
    q.delete();
    send(512'd0, 64'h100);
    chk("lat_n1_ovld", pack_ovld, 1'b0);
    send(512'd1, 64'h101);
    chk("lat_n2_ovld", pack_ovld, 1'b1);
    chk("lat_n2_sof", pack_osof, 1'b1);
    send(512'd2, 64'h102);
    send(512'd3, 64'h103);
    wait_beats(5, 50, "f0_beats");
    for (int i = 0; i < 5; i++)
      if (i < q.size())
        chk($sformatf("f0_beat%0d", i), {q[i].sof, q[i].last, q[i].dat},
            {tbl[i].sof, tbl[i].last, tbl[i].dat});
    repeat (2) tick();
    chk("f0_frame_cnt", frame_cnt, 32'd1);
    chk("f0_drop_cnt", drop_cnt, 32'd0);
    chk("f0_idle_ovld", pack_ovld, 1'b0);

    // Overflow with output stalled, then full-rate drain
    q.delete();
    pack_ordy = 1'b0;
    for (int k = 0; k < 40; k++) send(512'(32'h1000 + k), 64'(32'h2000 + k));
    chk("ovf_drop_cnt", drop_cnt, 32'd8);
    chk("ovf_hdr_held", {pack_ovld, pack_osof, pack_odat}, {2'b11, hdr(32'd1, 64'h2000, 1'b0)});
    pack_ordy = 1'b1;
    wait_beats(40, 200, "ovf_beats");
    if (q.size() >= 40) begin
      for (int f = 0; f < 8; f++) begin
        chk($sformatf("ovf_hdr%0d", f), {q[5*f].sof, q[5*f].last, q[5*f].dat},
            {2'b10, hdr(32'(1 + f), 64'(32'h2000 + 4*f), (f == 1))});
        for (int j = 0; j < 4; j++)
          chk($sformatf("ovf_f%0d_d%0d", f, j),
              {q[5*f+1+j].sof, q[5*f+1+j].last, q[5*f+1+j].dat},
              {1'b0, (j == 3), 512'(32'h1000 + 4*f + j)});
      end
      chk("ovf_no_gaps", q[39].cyc - q[0].cyc, 39);
    end
    tick();
    chk("ovf_frame_cnt", frame_cnt, 32'd9);
    soft_clear();
    chk("clr_frame_cnt", frame_cnt, 32'd0);
    chk("clr_drop_cnt", drop_cnt, 32'd0);

    // Random backpressure with sparse input
    q.delete();
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(5, 2)) begin
        pack_ordy = ($urandom_range(3, 0) != 0);
        tick();
      end
      pack_ordy = ($urandom_range(3, 0) != 0);
      din_q.push_back({448'd0, 32'($urandom), 32'(k)});
      enc_q.push_back(64'hABCD_0000_0000_0000 | 64'(k));
      send(din_q[k], enc_q[k]);
    end
    pack_ordy = 1'b1;
    wait_beats(1250, 500, "rnd_beats");
    nseq = 0; nfrm = 0; nhdr = 0;
    if (q.size() == 1250) begin
      for (int f = 0; f < 250; f++) begin
        wb = q[5*f];
        if (!(wb.sof && !wb.last && wb.dat == hdr(32'(f), enc_q[4*f], 1'b0))) nhdr++;
        for (int j = 0; j < 4; j++) begin
          wb = q[5*f+1+j];
          if (wb.sof || (wb.last != (j == 3))) nfrm++;
          if (wb.dat != din_q[4*f+j]) nseq++;
        end
      end
    end
    chk("rnd_order", nseq, 0);
    chk("rnd_framing", nfrm, 0);
    chk("rnd_headers", nhdr, 0);
    chk("rnd_drop_cnt", drop_cnt, 32'd0);
    chk("rnd_frame_cnt", frame_cnt, 32'd250);
    soft_clear();

    // Enable dropped mid-frame
    q.delete();
    for (int k = 0; k < 4; k++) send(512'(32'h300 + k), 64'(32'h400 + k));
    wait_beats(3, 20, "en_first_beats");
    cfg_pack_en = 1'b0;
    dc_save = drop_cnt;
    wait_beats(5, 20, "en_frame_done");
    if (q.size() >= 5) begin
      chk("en_d2", {q[3].sof, q[3].last, q[3].dat}, {2'b00, 512'h302});
      chk("en_d3", {q[4].sof, q[4].last, q[4].dat}, {2'b01, 512'h303});
    end
    repeat (4) tick();
    send(512'h3F0, 64'h4F0);
    send(512'h3F1, 64'h4F1);
    repeat (10) tick();
    chk("en_idle_ovld", pack_ovld, 1'b0);
    chk("en_drop_same", drop_cnt, dc_save);
    cfg_pack_en = 1'b1;
    repeat (8) tick();
    chk("en_discarded", q.size(), 5);

    // Soft clear during data beat 2
    q.delete();
    for (int k = 0; k < 4; k++) send(512'(32'h500 + k), 64'(32'h600 + k));
    wait_beats(3, 20, "clr_pre_beats");
    soft_clear();
    chk("clr_mid_out", {pack_ovld, pack_osof, pack_olast, pack_odat}, 515'd0);
    chk("clr_mid_frame_cnt", frame_cnt, 32'd0);
    chk("clr_mid_drop_cnt", drop_cnt, 32'd0);
    repeat (3) tick();
    chk("clr_no_last", q.size(), 3);
    for (int k = 0; k < 4; k++) send(512'(32'h700 + k), 64'(32'h800 + k));
    wait_beats(8, 30, "clr_post_beats");
    if (q.size() >= 8) begin
      chk("clr_new_hdr", {q[3].sof, q[3].dat}, {1'b1, hdr(32'd0, 64'h800, 1'b0)});
      chk("clr_new_last", {q[7].last, q[7].dat}, {1'b1, 512'h703});
    end
    repeat (2) tick();
    chk("clr_post_frame_cnt", frame_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_frame_pack.md
ACC_FRAME_PACK -- requirements
Module: acc_frame_pack

Interface
REQ-001 Parameters SHALL be: DATA_WD, 512, per-beat sample payload width (32 ch x 16 bit).
REQ-002 Parameters SHALL be: HEAD_WD, 64, encoder header width; bit 63 is the acc flag.
REQ-003 Parameters SHALL be: FRAME_LEN, 16, data beats per frame (2..256).
REQ-004 Parameters SHALL be: FIFO_DEPTH, 32, input buffer depth (power of 2).
REQ-005 The design SHALL use one clock, clk; reset is rst_n, synchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_rst  in  1  synchronous soft clear
- cfg_pack_en  in  1  framing enable (async cfg)
- acc_ivld  in  1  input sample valid, no backpressure
- acc_idat  in  DATA_WD  scaled sample word
- enc_idat  in  HEAD_WD  encoder header of sample
- pack_ordy  in  1  downstream ready
- pack_ovld  out  1  output beat valid
- pack_odat  out  DATA_WD  output beat
- pack_osof  out  1  header beat marker
- pack_olast  out  1  last data beat of frame
- frame_cnt  out  32  frames issued
- drop_cnt  out  32  samples lost to overflow

Function
REQ-007 cfg_pack_en SHALL pass through a 3-stage cmip_bit_sync_imp before use.
REQ-008 When acc_ivld=1, synced enable=1 and FIFO not full, {enc_idat, acc_idat} SHALL be written to the FIFO.
- When acc_ivld=1 while disabled: sample discarded, not counted.
REQ-009 When acc_ivld=1 with registered full=1, the sample SHALL be dropped even if a pop occurs the same cycle.
- drop_cnt increments by 1, saturating at 0xFFFF_FFFF.
- loss_flag is set.
REQ-010 FSM states SHALL be IDLE, HEAD, DATA.
- IDLE->HEAD: FIFO non-empty and synced enable=1.
- HEAD->DATA: on header handshake.
- DATA->HEAD: last-beat handshake with FIFO non-empty and enable=1.
- DATA->IDLE: last-beat handshake otherwise.
REQ-011 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes, then the FSM returns to IDLE.
REQ-012 Header beat layout SHALL be, all other bits 0:
- [511:480] = 32'h5A5A_A5A5
- [479:448] = frame_cnt value before increment
- [447:384] = enc_idat of the frame's first sample (FIFO head, not popped)
- [383:368] = FRAME_LEN
- [367] = loss_flag
REQ-013 Header handshake SHALL increment frame_cnt (wraps at 2^32) and clear loss_flag.
- A drop in the same cycle keeps loss_flag set.
REQ-014 Data beats SHALL carry the FIFO-head acc_idat unchanged.
- Each handshake pops one entry and increments beat_cnt.
- pack_olast=1 when beat_cnt=FRAME_LEN-1.
- pack_osof=1 only on header beats.
REQ-015 Outputs SHALL be registered; pack_odat/osof/olast SHALL hold stable while pack_ovld=1 and pack_ordy=0.
REQ-016 In DATA with the FIFO empty, pack_ovld SHALL be 0 (bubble); the frame resumes with no beat duplicated or skipped.
REQ-017 Latency SHALL be: sample written at cycle N into an empty FIFO in IDLE -> header pack_ovld=1 at N+2; first data beat no earlier than the cycle after the header handshake.
REQ-018 With pack_ordy held 1 and continuous input, throughput SHALL be FRAME_LEN+1 output beats per FRAME_LEN samples with no dead cycles.

Reset
REQ-019 rst_n=0 or cfg_rst=1 SHALL, on the clk edge, set the FSM to IDLE and clear FIFO pointers, beat_cnt, loss_flag, frame_cnt and drop_cnt.
REQ-020 Reset SHALL drive pack_ovld, pack_osof and pack_olast to 0 and pack_odat to 0.
REQ-021 Reset mid-frame SHALL abandon the frame without asserting pack_olast; the next frame starts with a fresh header.

Structure
REQ-022 Package acc_pack_pkg SHALL hold:
- magic 32'h5A5A_A5A5
- header field offsets
- FSM state encoding
REQ-023 Buffering SHALL be one sub-module, acc_sync_fifo: width DATA_WD+HEAD_WD, depth FIFO_DEPTH, registered full/empty, synchronous reset.

Verification
REQ-024 FRAME_LEN=4, ordy=1, 4 samples data=k, enc=0x100+k -> header (magic, frame 0, enc 0x100, len 4, loss 0), then data 0..3 with olast on data 3; frame_cnt=1.
REQ-025 ordy=0 with 40 continuous samples -> 32 stored, drop_cnt=8; after ordy=1 the second header shows loss=1.
REQ-026 Random ordy toggling over 1000 samples -> output data sequence equals input order; pack_odat stable during every stall; every frame is exactly header + FRAME_LEN beats.
REQ-027 cfg_pack_en dropped after data beat 1 of 4 -> beats 2 and 3 still issued, then IDLE; input samples after the sync delay are discarded with drop_cnt unchanged.
REQ-028 cfg_rst pulsed during data beat 2 -> next cycle pack_ovld=0 and counters=0; the next input produces a header with frame 0.
